// File: rtl/mul_pkg.sv
// rtl/mul_pkg.sv - shared state encoding for the iterative multiplier
package mul_pkg;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

endpackage

// File: rtl/mul_row.sv
// rtl/mul_row.sv - one WIDTH-bit partial-product row: AND-gated multiplicand added to acc_hi
module mul_row #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] mcand,
    input  logic             mbit,
    input  logic [WIDTH-1:0] acc_hi,
    output logic             carry,
    output logic [WIDTH-1:0] sum
);

    logic [WIDTH-1:0] row;

    assign row          = mcand & {WIDTH{mbit}};
    assign {carry, sum} = {1'b0, acc_hi} + {1'b0, row};

endmodule

// File: rtl/seq_mul.sv
// rtl/seq_mul.sv - shift-and-add multiplier, one row per cycle, signed or unsigned
module seq_mul
    import mul_pkg::*;
#(
    parameter  int WIDTH = 32,
    localparam int CNT_W = $clog2(WIDTH)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 is_signed,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 ready,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    logic [1:0]         state;
    logic [CNT_W-1:0]   cnt;
    logic [WIDTH-1:0]   mcand;
    logic [WIDTH-1:0]   acc_hi;
    logic [WIDTH-1:0]   acc_lo;
    logic               neg;

    logic               carry;
    logic [WIDTH-1:0]   sum;
    logic [2*WIDTH-1:0] shifted;

    // acc_lo starts as the multiplier: its LSB is consumed each cycle while
    // product bits enter from the top, so no separate multiplier register is needed.
    mul_row #(.WIDTH(WIDTH)) u_row (
        .mcand  (mcand),
        .mbit   (acc_lo[0]),
        .acc_hi (acc_hi),
        .carry  (carry),
        .sum    (sum)
    );

    assign shifted = {carry, sum, acc_lo[WIDTH-1:1]};

    assign ready = (state != S_CALC);
    assign busy  = (state == S_CALC);
    assign done  = (state == S_DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            cnt     <= '0;
            mcand   <= '0;
            acc_hi  <= '0;
            acc_lo  <= '0;
            neg     <= 1'b0;
            product <= '0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        // Most-negative operand maps to 2^(WIDTH-1), which still fits unsigned.
                        mcand  <= (is_signed && a[WIDTH-1]) ? -a : a;
                        acc_lo <= (is_signed && b[WIDTH-1]) ? -b : b;
                        neg    <= is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
                        acc_hi <= '0;
                        cnt    <= '0;
                        state  <= S_CALC;
                    end else begin
                        state  <= S_IDLE;
                    end
                end
                S_CALC: begin
                    {acc_hi, acc_lo} <= shifted;
                    cnt              <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        product <= neg ? -shifted : shifted;
                        state   <= S_DONE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_mul.sv
// tb/tb_seq_mul.sv - self-checking bench: vector table, corner sequences, random vs reference model
module tb_seq_mul;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst8_n, start8, sgn8, ready8, busy8, done8;
    logic [7:0]  a8, b8;
    logic [15:0] prod8;

    logic        rst32_n, start32, sgn32, ready32, busy32, done32;
    logic [31:0] a32, b32;
    logic [63:0] prod32;

    seq_mul #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst8_n), .start(start8), .is_signed(sgn8),
        .a(a8), .b(b8), .ready(ready8), .busy(busy8), .done(done8), .product(prod8)
    );

    seq_mul #(.WIDTH(32)) dut32 (
        .clk(clk), .rst_n(rst32_n), .start(start32), .is_signed(sgn32),
        .a(a32), .b(b32), .ready(ready32), .busy(busy32), .done(done32), .product(prod32)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] ref8(input logic s, input logic [7:0] x, input logic [7:0] y);
        int r;
        if (s) r = int'($signed(x)) * int'($signed(y));
        else   r = int'(x) * int'(y);
        return r[15:0];
    endfunction

    function automatic logic [63:0] ref32(input logic s, input logic [31:0] x, input logic [31:0] y);
        longint r;
        if (s) r = longint'($signed(x)) * longint'($signed(y));
        else   r = longint'({32'b0, x}) * longint'({32'b0, y});
        return r;
    endfunction

    task automatic op8(input string name, input logic s, input logic [7:0] x, input logic [7:0] y,
                       input logic [15:0] exp);
        int lat;
        @(negedge clk);
        start8 = 1'b1; sgn8 = s; a8 = x; b8 = y;
        @(posedge clk);
        @(negedge clk);
        start8 = 1'b0;
        chk({name, " busy"}, {63'b0, busy8 & ~ready8}, 64'd1);
        lat = 0;
        while (!done8 && lat < 64) begin
            @(negedge clk);
            lat++;
        end
        chk({name, " latency"}, 64'(lat), 64'd8);
        chk({name, " product"}, 64'(prod8), 64'(exp));
        @(negedge clk);
        chk({name, " done width"}, 64'(done8), 64'd0);
    endtask

    task automatic op32(input string name, input logic s, input logic [31:0] x, input logic [31:0] y,
                        input logic [63:0] exp);
        int lat;
        @(negedge clk);
        start32 = 1'b1; sgn32 = s; a32 = x; b32 = y;
        @(posedge clk);
        @(negedge clk);
        start32 = 1'b0;
        lat = 0;
        while (!done32 && lat < 128) begin
            @(negedge clk);
            lat++;
        end
        chk({name, " latency"}, 64'(lat), 64'd32);
        chk({name, " product"}, prod32, exp);
        @(negedge clk);
        chk({name, " done width"}, 64'(done32), 64'd0);
    endtask

    typedef struct {
        logic        sgn;
        logic [7:0]  a;
        logic [7:0]  b;
        logic [15:0] p;
    } vec_t;

    vec_t vecs[8];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int extra;
        logic        rs;
        logic [7:0]  ra, rb;
        logic [31:0] wa, wb;

        vecs[0] = '{1'b0, 8'd255, 8'd255, 16'd65025};
        vecs[1] = '{1'b1, 8'h80,  8'h80,  16'd16384};
        vecs[2] = '{1'b1, 8'hF9,  8'd9,   16'hFFC1};
        vecs[3] = '{1'b0, 8'd0,   8'd200, 16'd0};
        vecs[4] = '{1'b0, 8'd1,   8'd173, 16'd173};
        vecs[5] = '{1'b1, 8'hFF,  8'd1,   16'hFFFF};
        vecs[6] = '{1'b1, 8'h80,  8'h7F,  16'hC080};
        vecs[7] = '{1'b0, 8'h80,  8'hFF,  16'h7F80};

        rst8_n = 1'b0; start8 = 1'b0; sgn8 = 1'b0; a8 = '0; b8 = '0;
        rst32_n = 1'b0; start32 = 1'b0; sgn32 = 1'b0; a32 = '0; b32 = '0;
        repeat (3) @(negedge clk);
        chk("reset ready", 64'(ready8), 64'd1);
        chk("reset busy", 64'(busy8), 64'd0);
        chk("reset done", 64'(done8), 64'd0);
        chk("reset product", 64'(prod8), 64'd0);
        chk("reset32 state", {61'b0, ready32, busy32, done32}, 64'b100);
        chk("reset32 product", prod32, 64'd0);
        rst8_n = 1'b1; rst32_n = 1'b1;

        for (int i = 0; i < 8; i++)
            op8($sformatf("vec%0d", i), vecs[i].sgn, vecs[i].a, vecs[i].b, vecs[i].p);

        // Back-to-back: start held high through DONE; operands changed during CALC are ignored.
        @(negedge clk);
        start8 = 1'b1; sgn8 = 1'b0; a8 = 8'd3; b8 = 8'd5;
        @(posedge clk);
        @(negedge clk);
        a8 = 8'd12; b8 = 8'd11;
        lat = 0;
        while (!done8 && lat < 64) begin
            @(negedge clk);
            lat++;
        end
        chk("b2b first latency", 64'(lat), 64'd8);
        chk("b2b first product", 64'(prod8), 64'd15);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
            if (lat == 1) chk("b2b done width", 64'(done8), 64'd0);
            if (lat == 4) chk("b2b product held", 64'(prod8), 64'd15);
        end while (!done8 && lat < 64);
        chk("b2b spacing", 64'(lat), 64'd9);
        chk("b2b second product", 64'(prod8), 64'd132);
        start8 = 1'b0;
        @(negedge clk);
        chk("b2b idle after", {61'b0, ready8, busy8, done8}, 64'b100);

        // start pulse during CALC must be ignored.
        @(negedge clk);
        start8 = 1'b1; sgn8 = 1'b0; a8 = 8'd10; b8 = 8'd10;
        @(posedge clk);
        @(negedge clk);
        start8 = 1'b0;
        repeat (2) @(negedge clk);
        start8 = 1'b1; a8 = 8'd2; b8 = 8'd2;
        @(negedge clk);
        start8 = 1'b0;
        lat = 3;
        while (!done8 && lat < 64) begin
            @(negedge clk);
            lat++;
        end
        chk("ignore latency", 64'(lat), 64'd8);
        chk("ignore product", 64'(prod8), 64'd100);
        extra = 0;
        repeat (30) begin
            @(negedge clk);
            if (done8) extra++;
        end
        chk("ignore no extra done", 64'(extra), 64'd0);

        // Reset in the middle of CALC aborts without a done pulse.
        @(negedge clk);
        start8 = 1'b1; sgn8 = 1'b0; a8 = 8'd50; b8 = 8'd3;
        @(posedge clk);
        @(negedge clk);
        start8 = 1'b0;
        repeat (4) @(negedge clk);
        rst8_n = 1'b0;
        #1;
        chk("midreset state", {61'b0, ready8, busy8, done8}, 64'b100);
        chk("midreset product", 64'(prod8), 64'd0);
        @(negedge clk);
        rst8_n = 1'b1;
        extra = 0;
        repeat (20) begin
            @(negedge clk);
            if (done8) extra++;
        end
        chk("midreset no done", 64'(extra), 64'd0);
        op8("post reset 6x7", 1'b0, 8'd6, 8'd7, 16'd42);

        for (int i = 0; i < 40; i++) begin
            rs = 1'($urandom_range(0, 1));
            ra = 8'($urandom);
            rb = 8'($urandom);
            op8($sformatf("rand8_%0d", i), rs, ra, rb, ref8(rs, ra, rb));
        end

        op32("w32 min*min", 1'b1, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000);
        op32("w32 max*max", 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001);
        op32("w32 -1*1", 1'b1, 32'hFFFF_FFFF, 32'd1, 64'hFFFF_FFFF_FFFF_FFFF);
        for (int i = 0; i < 40; i++) begin
            rs = 1'($urandom_range(0, 1));
            wa = $urandom;
            wb = $urandom;
            op32($sformatf("rand32_%0d", i), rs, wa, wb, ref32(rs, wa, wb));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
